// File: rtl/tlp_chan_mux.sv
// Shares one host TLP pipe pair between NUM_CHANS application channels:
// rx TLPs are steered by BAR hit, tx TLPs are arbitrated round-robin per packet.
module tlp_chan_mux #(
  parameter int NUM_CHANS = 2,
  parameter int DROP_W    = 16
) (
  input  logic                          pcieClk_in,
  input  logic                          pcieNPOR_in,
  input  logic [63:0]                   rxData_in,
  input  logic                          rxSOP_in,
  input  logic [2:0]                    rxBar_in,
  input  logic                          rxEOP_in,
  input  logic                          rxValid_in,
  output logic                          rxReady_out,
  output logic [NUM_CHANS-1:0][63:0]    chanRxData_out,
  output logic [NUM_CHANS-1:0]          chanRxSOP_out,
  output logic [NUM_CHANS-1:0]          chanRxEOP_out,
  output logic [NUM_CHANS-1:0]          chanRxValid_out,
  input  logic [NUM_CHANS-1:0]          chanRxReady_in,
  input  logic [NUM_CHANS-1:0][63:0]    chanTxData_in,
  input  logic [NUM_CHANS-1:0]          chanTxSOP_in,
  input  logic [NUM_CHANS-1:0]          chanTxEOP_in,
  input  logic [NUM_CHANS-1:0]          chanTxValid_in,
  output logic [NUM_CHANS-1:0]          chanTxReady_out,
  output logic [63:0]                   txData_out,
  output logic                          txSOP_out,
  output logic                          txEOP_out,
  output logic                          txValid_out,
  input  logic                          txReady_in,
  output logic [DROP_W-1:0]             dropCount_out
);
  localparam int DATA_W = 64;
  localparam int CH_W   = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;

  typedef enum logic {RX_IDLE, RX_BUSY} rxState_t;
  typedef enum logic {TX_IDLE, TX_LOCKED} txState_t;

  rxState_t          rxState;
  logic [CH_W-1:0]   rxDest;
  logic              rxDrop;
  logic [DROP_W-1:0] dropCount;
  logic              barMapped;
  logic              rxFwd;
  logic [CH_W-1:0]   rxSel;
  logic              rxAcc;
  logic              rxXfer;

  txState_t          txState;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   lastGrant;
  logic [CH_W-1:0]   txCand;
  logic              txFound;
  logic              txFwd;
  logic [CH_W-1:0]   txSel;
  logic              txXfer;

  assign dropCount_out = dropCount;

  // Rx steering: everything not headed to a live channel is accepted and discarded
  always_comb begin
    barMapped = ({1'b0, rxBar_in} < 4'(NUM_CHANS));
    rxSel     = rxDest;
    rxFwd     = 1'b0;
    if (rxState == RX_BUSY) begin
      rxFwd = !rxDrop;
    end else if (rxSOP_in && barMapped) begin
      rxSel = CH_W'(rxBar_in);
      rxFwd = 1'b1;
    end
    rxAcc = rxFwd ? chanRxReady_in[rxSel] : 1'b1;
    rxReady_out     = pcieNPOR_in & rxAcc;
    chanRxValid_out = '0;
    if (pcieNPOR_in && rxValid_in && rxFwd)
      chanRxValid_out[rxSel] = 1'b1;
    for (int c = 0; c < NUM_CHANS; c++)
      chanRxData_out[c] = pcieNPOR_in ? rxData_in : '0;
    chanRxSOP_out = {NUM_CHANS{pcieNPOR_in & rxSOP_in}};
    chanRxEOP_out = {NUM_CHANS{pcieNPOR_in & rxEOP_in}};
    rxXfer        = rxValid_in & rxReady_out;
  end

  always_ff @(posedge pcieClk_in or negedge pcieNPOR_in) begin
    if (!pcieNPOR_in) begin
      rxState   <= RX_IDLE;
      rxDest    <= '0;
      rxDrop    <= 1'b0;
      dropCount <= '0;
    end else if (rxXfer) begin
      if (rxState == RX_IDLE) begin
        if (rxSOP_in) begin
          if (!barMapped && dropCount != '1)
            dropCount <= dropCount + 1'b1;
          if (!rxEOP_in) begin
            rxState <= RX_BUSY;
            rxDest  <= rxSel;
            rxDrop  <= !barMapped;
          end
        end
      end else if (rxEOP_in) begin
        rxState <= RX_IDLE;
      end
    end
  end

  // Descending scan so the nearest requester after lastGrant wins
  always_comb begin
    txCand  = lastGrant;
    txFound = 1'b0;
    for (int i = NUM_CHANS; i >= 1; i--) begin
      if (chanTxValid_in[(int'(lastGrant) + i) % NUM_CHANS] &&
          chanTxSOP_in[(int'(lastGrant) + i) % NUM_CHANS]) begin
        txFound = 1'b1;
        txCand  = CH_W'((int'(lastGrant) + i) % NUM_CHANS);
      end
    end
    txSel = grant;
    txFwd = 1'b0;
    if (txState == TX_LOCKED) begin
      txFwd = 1'b1;
    end else if (txFound) begin
      txSel = txCand;
      txFwd = 1'b1;
    end
    txFwd       = txFwd & pcieNPOR_in;
    txValid_out = txFwd & chanTxValid_in[txSel];
    txData_out  = txValid_out ? chanTxData_in[txSel] : {DATA_W{1'b0}};
    txSOP_out   = txValid_out & chanTxSOP_in[txSel];
    txEOP_out   = txValid_out & chanTxEOP_in[txSel];
    chanTxReady_out = '0;
    if (txFwd)
      chanTxReady_out[txSel] = txReady_in;
    txXfer = txValid_out & txReady_in;
  end

  always_ff @(posedge pcieClk_in or negedge pcieNPOR_in) begin
    if (!pcieNPOR_in) begin
      txState   <= TX_IDLE;
      grant     <= '0;
      lastGrant <= CH_W'(NUM_CHANS - 1);
    end else if (txXfer) begin
      if (txState == TX_IDLE) begin
        grant     <= txSel;
        lastGrant <= txSel;
        if (!txEOP_out)
          txState <= TX_LOCKED;
      end else if (txEOP_out) begin
        txState <= TX_IDLE;
      end
    end
  end

endmodule

// File: doc/tlp_chan_mux.md
TLP_CHAN_MUX -- requirements
Module: tlp_chan_mux

Interface
REQ-001 SHALL have parameter NUM_CHANS, default 2, number of application channels sharing one TLP pipe pair (legal 1..8).
REQ-002 SHALL have parameter DROP_W, default 16, width of the unmapped-BAR drop counter.
REQ-003 SHALL have ports, one per line, clock and reset first; one clock, reset asynchronous and active-low:
- pcieClk_in  in  1  sole clock
- pcieNPOR_in  in  1  asynchronous active-low reset
- rxData_in  in  64  host->FPGA beat data
- rxSOP_in  in  1  first beat of a TLP
- rxBar_in  in  3  BAR hit; meaningful only on SOP beats
- rxEOP_in  in  1  last beat of a TLP
- rxValid_in  in  1  rx beat valid
- rxReady_out  out  1  rx beat accepted
- chanRxData_out  out  NUM_CHANS x 64  per-channel rx data
- chanRxSOP_out / chanRxEOP_out / chanRxValid_out  out  NUM_CHANS each  per-channel rx framing
- chanRxReady_in  in  NUM_CHANS  per-channel rx ready
- chanTxData_in  in  NUM_CHANS x 64  per-channel tx data
- chanTxSOP_in / chanTxEOP_in / chanTxValid_in  in  NUM_CHANS each  per-channel tx framing
- chanTxReady_out  out  NUM_CHANS  per-channel tx accepted
- txData_out  out  64  FPGA->host data
- txSOP_out / txEOP_out / txValid_out  out  1 each  FPGA->host framing
- txReady_in  in  1  FPGA->host ready
- dropCount_out  out  DROP_W  rx TLPs discarded for unmapped BAR

Function
REQ-004 SHALL treat a beat as transferred only in a cycle where its valid and ready are both high.
REQ-005 SHALL implement an rx FSM with states RX_IDLE and RX_BUSY plus registers rxDest and rxDrop.
REQ-006 In RX_IDLE, a valid SOP beat SHALL be routed combinationally, with zero latency, to channel rxBar_in if rxBar_in < NUM_CHANS; rxReady_out SHALL equal chanRxReady_in[rxBar_in].
REQ-007 In RX_IDLE, a valid SOP beat with rxBar_in >= NUM_CHANS SHALL be dropped: rxReady_out=1, no chanRxValid_out asserted.
REQ-008 A transferred SOP beat without EOP SHALL latch rxDest and rxDrop and move to RX_BUSY; a transferred SOP+EOP beat SHALL stay in RX_IDLE.
REQ-009 In RX_BUSY, beats SHALL go to rxDest, or be dropped if rxDrop is set; the FSM SHALL return to RX_IDLE on the transferred EOP beat.
REQ-010 In RX_IDLE, a valid non-SOP beat SHALL be discarded with rxReady_out=1 (framing recovery).
REQ-011 Only the selected channel's chanRxValid_out SHALL be high; chanRxData/SOP/EOP_out SHALL broadcast rxData_in to all channels.
REQ-012 dropCount_out SHALL increment by 1 on each transferred dropped SOP beat and saturate at all-ones.
REQ-013 SHALL implement a tx FSM with states TX_IDLE and TX_LOCKED plus registers grant and lastGrant.
REQ-014 In TX_IDLE, grant SHALL be the first channel c with chanTxValid_in[c]&chanTxSOP_in[c], searching round-robin from lastGrant+1 mod NUM_CHANS; that channel SHALL pass through combinationally in the same cycle.
REQ-015 On a transferred beat in TX_IDLE, lastGrant SHALL update to the granted channel; without EOP the FSM SHALL move to TX_LOCKED, with EOP it SHALL stay in TX_IDLE.
REQ-016 In TX_LOCKED, only the granted channel SHALL be forwarded; the FSM SHALL return to TX_IDLE on its transferred EOP beat; a packet SHALL never be interleaved.
REQ-017 chanTxReady_out[c] SHALL equal txReady_in for the forwarded channel and 0 otherwise; non-SOP valid beats of ungranted channels in TX_IDLE SHALL stall.
REQ-018 With no eligible requester, txValid_out SHALL be 0 and txData_out/txSOP_out/txEOP_out SHALL be 0.
REQ-019 Rx and tx paths SHALL be fully independent and SHALL progress in the same cycle.

Reset
REQ-020 While pcieNPOR_in=0: FSMs SHALL be in RX_IDLE/TX_IDLE, rxDest=0, rxDrop=0, grant=0, lastGrant=NUM_CHANS-1, dropCount_out=0, and every valid/ready output SHALL be 0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet immediately; after release, both FSMs SHALL accept only SOP-led traffic.

Verification
REQ-022 NUM_CHANS=2, rx 3-beat TLP with rxBar_in=1 -> all 3 beats appear on channel 1 only, with SOP on beat 0 and EOP on beat 2.
REQ-023 Rx SOP+EOP beat with rxBar_in=5 -> rxReady_out=1, no channel valid, dropCount_out 0->1; 0xFFFF held -> stays 0xFFFF.
REQ-024 Both channels present 2-beat tx TLPs continuously after reset -> packets on txData_out ordered ch0, ch1, ch0, ch1, never interleaved.
REQ-025 txReady_in=0 for 4 cycles mid-packet of ch1 -> tx output held stable, ch0 not granted until ch1's EOP transfers.
REQ-026 pcieNPOR_in pulsed low on beat 1 of a 4-beat rx TLP -> all outputs 0 during reset; after release, beats 2-3 discarded, next SOP routed correctly.
